// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: pixel-rate divider, h/v counters, registered sync/bright decodes,
// end-of-frame strobe and a free-running frame counter.
module vga_timing_gen #(
  parameter int CLK_DIV     = 4,
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_ACT_START = 144,
  parameter int H_ACT_END   = 784,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_ACT_START = 35,
  parameter int V_ACT_END   = 515
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pixel_tick,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       hSync,
  output logic       vSync,
  output logic       bright,
  output logic       frame_end,
  output logic [7:0] frame_count
);

  localparam int              DIV_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_C = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_C = 10'(V_SYNC);
  localparam logic [9:0] H_AS     = 10'(H_ACT_START);
  localparam logic [9:0] H_AE     = 10'(H_ACT_END);
  localparam logic [9:0] V_AS     = 10'(V_ACT_START);
  localparam logic [9:0] V_AE     = 10'(V_ACT_END);

  typedef struct packed {
    logic hs;
    logic vs;
    logic br;
  } dec_t;

  function automatic dec_t decode(input logic [9:0] h, input logic [9:0] v);
    dec_t d;
    d.hs = ~(h < H_SYNC_C);
    d.vs = ~(v < V_SYNC_C);
    d.br = (h >= H_AS) && (h < H_AE) && (v >= V_AS) && (v < V_AE);
    return d;
  endfunction

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic [7:0]       fc_q, fc_d;
  dec_t             dec_q, dec_d;
  logic             tick, h_last, v_last;

  always_comb begin
    tick   = (div_q == DIV_LAST);
    h_last = (h_q == H_LAST);
    v_last = (v_q == V_LAST);
    div_d  = tick ? '0 : div_q + 1'b1;
    h_d    = h_q;
    v_d    = v_q;
    fc_d   = fc_q;
    if (tick) begin
      if (h_last) begin
        h_d = '0;
        if (v_last) begin
          v_d  = '0;
          fc_d = fc_q + 8'd1;
        end else begin
          v_d = v_q + 10'd1;
        end
      end else begin
        h_d = h_q + 10'd1;
      end
    end
    // Decode the next position so the registered flags line up with the counters.
    dec_d = decode(h_d, v_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
      fc_q  <= '0;
      dec_q <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      fc_q  <= fc_d;
      dec_q <= dec_d;
    end
  end

  assign pixel_tick  = tick;
  assign hCount      = h_q;
  assign vCount      = v_q;
  assign hSync       = dec_q.hs;
  assign vSync       = dec_q.vs;
  assign bright      = dec_q.br;
  assign frame_end   = tick && h_last && v_last;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size instance for line/sync timing, reduced instance
// scoreboarded pixel by pixel across 256 frames plus a mid-frame reset.
module tb_vga_timing_gen;

  // Reduced raster used for the scoreboarded instance
  localparam int SDIV = 2;
  localparam int SHT  = 12;
  localparam int SVT  = 6;
  localparam int SFRM = SHT * SVT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       f_tick, f_hs, f_vs, f_br, f_fe;
  logic [9:0] f_h, f_v;
  logic [7:0] f_fc;
  logic       s_tick, s_hs, s_vs, s_br, s_fe;
  logic [9:0] s_h, s_v;
  logic [7:0] s_fc;

  vga_timing_gen u_full (
    .clk(clk), .reset(rst_n), .pixel_tick(f_tick), .hCount(f_h), .vCount(f_v),
    .hSync(f_hs), .vSync(f_vs), .bright(f_br), .frame_end(f_fe), .frame_count(f_fc)
  );

  vga_timing_gen #(
    .CLK_DIV(SDIV), .H_TOTAL(SHT), .H_SYNC(2), .H_ACT_START(3), .H_ACT_END(10),
    .V_TOTAL(SVT), .V_SYNC(1), .V_ACT_START(2), .V_ACT_END(5)
  ) u_small (
    .clk(clk), .reset(rst_n), .pixel_tick(s_tick), .hCount(s_h), .vCount(s_v),
    .hSync(s_hs), .vSync(s_vs), .bright(s_br), .frame_end(s_fe), .frame_count(s_fc)
  );

  typedef struct packed {
    int         cyc;
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       br;
    logic       fe;
    logic [7:0] fc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_exp, mon_act;
  int   errors = 0, checks = 0;
  int   cyc;
  logic sb_en = 1'b0, full_en = 1'b0;
  int   fe_cyc = 0, br_ticks = 0, fc_max = 0;
  int   hs_low0 = 0, tick0 = 0, vs_low = 0, br_hi = 0;
  int   h_end = -1, v_end = -1, h_wrap = -1, v_wrap = -1, vs_6400 = -1;

  // Rising edges since reset release
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Expected pixel k of the reduced raster, derived from the tick index alone
  task automatic push_ticks(input int n);
    exp_t e;
    int   h, v;
    for (int k = 0; k < n; k++) begin
      h     = k % SHT;
      v     = (k / SHT) % SVT;
      e.cyc = k * SDIV + SDIV - 1;
      e.h   = 10'(h);
      e.v   = 10'(v);
      e.hs  = (h >= 2);
      e.vs  = (v >= 1);
      e.br  = (h >= 3) && (h < 10) && (v >= 2) && (v < 5);
      e.fe  = (h == 11) && (v == 5);
      e.fc  = 8'((k / SFRM) % 256);
      sb_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (sb_en) begin
      if (s_fe) fe_cyc++;
      if (s_tick) begin
        if (s_br) br_ticks++;
        if (int'(s_fc) > fc_max) fc_max = int'(s_fc);
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra_tick: got tick at cyc=%0d h=%0d v=%0d expected none", cyc, s_h, s_v);
        end else begin
          mon_exp = sb_q.pop_front();
          mon_act = '{cyc: cyc, h: s_h, v: s_v, hs: s_hs, vs: s_vs, br: s_br, fe: s_fe, fc: s_fc};
          if (mon_act !== mon_exp) begin
            errors++;
            $display("FAIL sb_pixel: got cyc=%0d h=%0d v=%0d hs=%0b vs=%0b br=%0b fe=%0b fc=%0d expected cyc=%0d h=%0d v=%0d hs=%0b vs=%0b br=%0b fe=%0b fc=%0d",
                     mon_act.cyc, mon_act.h, mon_act.v, mon_act.hs, mon_act.vs, mon_act.br, mon_act.fe, mon_act.fc,
                     mon_exp.cyc, mon_exp.h, mon_exp.v, mon_exp.hs, mon_exp.vs, mon_exp.br, mon_exp.fe, mon_exp.fc);
          end
        end
      end
    end
  end

  // Full-size raster measurements over the first two lines
  always @(negedge clk) begin
    if (full_en && rst_n) begin
      if (cyc < 3200) begin
        if (!f_hs)  hs_low0++;
        if (f_tick) tick0++;
      end
      if (cyc == 3199) begin h_end = f_h; v_end = f_v; end
      if (cyc == 3200) begin h_wrap = f_h; v_wrap = f_v; end
      if (cyc < 6400) begin
        if (!f_vs) vs_low++;
        if (f_br)  br_hi++;
      end
      if (cyc == 6400) vs_6400 = f_vs;
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_full_cnt"},  {f_h, f_v, f_fc}, 0);
    chk({tag, "_full_flag"}, {f_tick, f_hs, f_vs, f_br, f_fe}, 0);
    chk({tag, "_small_cnt"}, {s_h, s_v, s_fc}, 0);
    chk({tag, "_small_flag"}, {s_tick, s_hs, s_vs, s_br, s_fe}, 0);
  endtask

  // Entered just after the releasing edge; first sample is before edge 1
  task automatic check_startup(input string tag);
    for (int e = 0; e <= 4; e++) begin
      @(negedge clk);
      chk({tag, "_h"},    f_h,    (e == 4) ? 1 : 0);
      chk({tag, "_tick"}, f_tick, (e == 3) ? 1 : 0);
    end
  endtask

  task automatic drain(input int limit);
    int g;
    g = 0;
    while (sb_q.size() != 0 && g < limit) begin
      @(negedge clk);
      g++;
    end
    chk("sb_drain_left", sb_q.size(), 0);
  endtask

  initial begin
    int found;
    repeat (3) @(negedge clk);
    chk_reset_vals("por");

    push_ticks(256 * SFRM + 20);
    sb_en   = 1'b1;
    full_en = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_startup("start");

    while (cyc < 6401) @(negedge clk);
    full_en = 1'b0;
    chk("line_hsync_low",  hs_low0, 384);
    chk("line_ticks",      tick0,   800);
    chk("line_end_h",      h_end,   799);
    chk("line_end_v",      v_end,   0);
    chk("line_wrap_h",     h_wrap,  0);
    chk("line_wrap_v",     v_wrap,  1);
    chk("vsync_low",       vs_low,  6400);
    chk("vsync_rise",      vs_6400, 1);
    chk("bright_top_rows", br_hi,   0);

    drain(40000);
    sb_en = 1'b0;
    chk("frame_end_cycles", fe_cyc,   256);
    chk("bright_ticks",     br_ticks, 21 * 256);
    chk("frame_count_max",  fc_max,   255);

    found = 0;
    for (int g = 0; g < 400 && found == 0; g++) begin
      @(negedge clk);
      if (s_h == 10'd6 && s_v == 10'd3) found = 1;
    end
    chk("mid_pos_found", found, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async");
    repeat (2) @(posedge clk);
    chk_reset_vals("held");
    sb_q.delete();
    push_ticks(2 * SFRM + 5);
    sb_en = 1'b1;
    #1 rst_n = 1'b1;
    check_startup("restart");
    drain(1000);
    sb_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates the 640x480@60 Hz VGA raster timing for the Nexys4 display path: pixel-rate tick, horizontal/vertical counters, sync pulses and the active-video (bright) flag. Its hCount/vCount/bright outputs are the inputs the pixel-colour logic (vga_bitchange) consumes, and its hSync/vSync drive the VGA connector directly. It also provides an end-of-frame strobe and a frame counter so game logic can advance once per frame.

## Interface
- CLK_DIV, 4: system clocks per pixel (100 MHz / 4 = 25 MHz pixel rate); legal 2..16
- H_TOTAL, 800: pixels per line
- H_SYNC, 96: hSync low width in pixels, starting at hCount 0
- H_ACT_START, 144: first active column
- H_ACT_END, 784: first column after active video (exclusive)
- V_TOTAL, 525: lines per frame
- V_SYNC, 2: vSync low width in lines, starting at vCount 0
- V_ACT_START, 35: first active line
- V_ACT_END, 515: first line after active video (exclusive)
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-low reset
- pixel_tick  out  1  high one clk per pixel period; counters advance on the clk edge that ends it
- hCount  out  10  horizontal pixel position, 0..H_TOTAL-1
- vCount  out  10  vertical line position, 0..V_TOTAL-1
- hSync  out  1  active-low horizontal sync
- vSync  out  1  active-low vertical sync
- bright  out  1  high inside the active window
- frame_end  out  1  one-clk strobe on the last pixel tick of a frame
- frame_count  out  8  frames completed since reset, wraps 255->0

## Operation
- Divider: counter div, 0..CLK_DIV-1, increments every clk, wraps to 0. pixel_tick = (div == CLK_DIV-1).
- On a clk edge with pixel_tick high:
  - hCount < H_TOTAL-1: hCount+1.
  - hCount == H_TOTAL-1: hCount->0; vCount+1, or vCount->0 if vCount == V_TOTAL-1.
  - hCount == H_TOTAL-1 and vCount == V_TOTAL-1: frame_count+1 (mod 256).
- Without pixel_tick, hCount/vCount/frame_count hold.
- Decodes, all from the current counter registers (valid in the same cycle as the counters they describe):
  - hSync = ~(hCount < H_SYNC); vSync = ~(vCount < V_SYNC).
  - bright = (H_ACT_START <= hCount < H_ACT_END) && (V_ACT_START <= vCount < V_ACT_END).
  - frame_end = pixel_tick && hCount == H_TOTAL-1 && vCount == V_TOTAL-1.
- hSync, vSync and bright are registered outputs: their registers load the decode of the next counter values on the same edge the counters update, so outputs never glitch and stay aligned with hCount/vCount.
- Counters never take values >= their TOTAL; the equality-based wrap is the only wrap path.

## Timing
- Reset (reset low, asynchronous): div=0, hCount=0, vCount=0, frame_count=0, pixel_tick=0, frame_end=0, bright=0, hSync=0, vSync=0 (position (0,0) lies inside both sync pulses).
- After reset release, the first pixel_tick is in the cycle after the 3rd rising edge; hCount becomes 1 on the 4th rising edge. hCount then changes every CLK_DIV clks.
- Line period H_TOTAL*CLK_DIV = 3200 clks; hSync low 384 clks per line.
- Frame period 525*3200 = 1,680,000 clks; vSync low 6400 clks per frame.
- bright first rises on the edge where (hCount,vCount) becomes (144,35); it stays high 640 pixels (2560 clks) per active line, for 480 lines.
- frame_end is high for exactly one clk per frame, coincident with pixel_tick; the edge ending it sets hCount=0, vCount=0 and frame_count+1.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronously); timing restarts from (0,0) with a full divider period.

## Test plan
- Reset values: hold reset low, then release -> all outputs at reset values; hCount 0->1 on the 4th rising edge after release; pixel_tick high every 4th clk thereafter.
- Horizontal timing: measure one line -> hSync low exactly 384 clks, line period 3200 clks, hCount wraps 799->0 while vCount increments by 1.
- Vertical timing: run one full frame -> vSync low 6400 clks, vCount wraps 524->0, frame_end pulses once (1 clk) at (799,524), frame period 1,680,000 clks.
- Active window: count bright-high pixel ticks per frame -> 307,200; first is (144,35), last is (783,514); bright low at (784,35) and (144,515).
- frame_count wrap: run 256 frames (use CLK_DIV=2 with reduced TOTAL parameters) -> frame_count goes 255->0 on the 256th frame_end.
- Mid-operation reset: assert reset at (400,300) for 2 clks -> outputs reset asynchronously in the same cycle; after release, the sequence is identical to the post-power-up sequence.
